// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive sequencer for an oversampled UART.
// Synchronizes rx, finds the start bit, samples every bit at mid-period with
// an oversample tick counter, assembles LSB-first data, checks the stop bit
// and hands words to the consumer through a rx_valid/rd_ack handshake.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// data and stop bits (input parity_odd_sel: 0 = even, 1 = odd).
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 rd_ack,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd_sel,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = S_PARITY;
`else
  localparam state_t AFTER_DATA = S_STOP;
`endif

  state_t                 state;
  state_t                 state_next;
  logic                   rx_meta;
  logic                   rxs;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   sample;
  logic                   load;
  logic                   ferr_set;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit;
  logic                   par_bad;
  logic                   perr_set;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: each sampling state advances only on its sample point.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (!rxs) state_next = S_START;
      S_START:  if (sample) state_next = rxs ? S_IDLE : S_DATA;
      S_DATA:   if (sample && (bit_idx == LAST_BIT)) state_next = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (sample) state_next = S_STOP;
`endif
      S_STOP:   if (sample) state_next = rxs ? S_IDLE : S_BREAK;
      S_BREAK:  if (rxs) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  // Received parity must make the total count of ones even (odd when selected).
  assign par_bad = ((^shreg) ^ par_bit) != parity_odd_sel;
`endif

  // Output decode: sample points and the actions taken at the stop sample.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    sample   = 1'b0;
    load     = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set = 1'b0;
`endif
    case (state)
      S_START:  sample = baud_tick && (cnt == HALF_LAST);
      S_DATA:   sample = baud_tick && (cnt == FULL_LAST);
`ifdef UART_RX_PARITY_EN
      S_PARITY: sample = baud_tick && (cnt == FULL_LAST);
`endif
      S_STOP:   sample = baud_tick && (cnt == FULL_LAST);
      default:  sample = 1'b0;
    endcase
    if ((state == S_STOP) && sample) begin
      ferr_set = !rxs;
`ifdef UART_RX_PARITY_EN
      perr_set = par_bad;
      load     = rxs && !par_bad;
`else
      load     = rxs;
`endif
    end
  end

  // Tick counter, bit index and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      // Restart timing on every state entry and after every sample.
      if ((state_next != state) || sample || (state == S_IDLE) || (state == S_BREAK))
        cnt <= '0;
      else if (baud_tick)
        cnt <= cnt + CW'(1);

      if (state == S_START)
        bit_idx <= '0;
      else if ((state == S_DATA) && sample)
        bit_idx <= bit_idx + BW'(1);

      // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
      if ((state == S_DATA) && sample)
        shreg <= {rxs, shreg[DATA_BITS-1:1]};

`ifdef UART_RX_PARITY_EN
      if ((state == S_PARITY) && sample)
        par_bit <= rxs;
`endif
    end
  end

  // Consumer-facing registers: word, handshake, flags and busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= load && rx_valid && !rd_ack;
      busy      <= (state_next != S_IDLE);
      // A fresh word wins over a same-cycle acknowledge.
      if (load) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rd_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error pulse, aligned with the cycle the word would have loaded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_err <= 1'b0;
    else        parity_err <= perr_set;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: scenario tasks plus randomized frames checked
// against a word-level model (last good word, unread flag, flag pulse counts).
module tb_uart_rx_ctrl;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rd_ack = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd_sel = 1'b0;
`endif
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun, busy;

  int tests_run = 0;
  int tests_failed = 0;
  int tick_div = 4;
  int div_cnt = 0;
  int ferr_seen = 0, perr_seen = 0, ovr_seen = 0;

  // Reference model state
  logic [7:0] exp_data = 8'h00;
  bit         exp_valid = 1'b0;
  int         exp_ferr = 0, exp_perr = 0, exp_ovr = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE)) dut (
    .clk(clk),
    .reset(reset),
    .baud_tick(baud_tick),
    .rx(rx),
    .rd_ack(rd_ack),
`ifdef UART_RX_PARITY_EN
    .parity_odd_sel(parity_odd_sel),
`endif
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .overrun(overrun),
    .busy(busy)
  );

  // baud_tick: one pulse every tick_div clocks, continuously high when tick_div is 1
  initial begin
    forever begin
      @(negedge clk);
      if (tick_div <= 1) baud_tick = 1'b1;
      else begin
        baud_tick = (div_cnt == 0);
        div_cnt = (div_cnt + 1) % tick_div;
      end
    end
  end

  // Pulse monitor: counts flag cycles
  initial begin
    forever begin
      @(negedge clk);
      if (frame_err === 1'b1) ferr_seen++;
      if (parity_err === 1'b1) perr_seen++;
      if (overrun === 1'b1) ovr_seen++;
    end
  end

  function automatic int bit_clks();
    return OVERSAMPLE * ((tick_div < 1) ? 1 : tick_div);
  endfunction

  task automatic send_bit(input logic b);
    rx = b;
    repeat (bit_clks()) @(negedge clk);
  endtask

  // Model: a good frame replaces the word; flags count bad frames and overwrites
  task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok, input bit ack_same);
    if (!par_ok) exp_perr++;
    if (!stop_ok) exp_ferr++;
    if (stop_ok && par_ok) begin
      if (exp_valid && !ack_same) exp_ovr++;
      exp_valid = 1'b1;
      exp_data = d;
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok, input bit ack_same);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) q.push_back(d[i]);
`ifdef UART_RX_PARITY_EN
    q.push_back((^d) ^ parity_odd_sel ^ !par_ok);
`endif
    q.push_back(stop_ok);
    foreach (q[i]) send_bit(q[i]);
    model_frame(d, stop_ok, par_ok, ack_same);
    rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_ack();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    exp_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %0h want 0", rx_data); end
    tests_run++; if ({rx_valid, frame_err, parity_err, overrun, busy} !== 5'b0) begin tests_failed++; $display("FAIL reset_flags: got %b want 00000", {rx_valid, frame_err, parity_err, overrun, busy}); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    tick_div = 4;
    run_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    tests_run++; if (rx_data !== 8'hA5) begin tests_failed++; $display("FAIL basic_data: got %0h want a5", rx_data); end
    tests_run++; if (rx_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %b want 1", rx_valid); end
    do_ack();
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_ack: got %b want 0", rx_valid); end
    tests_run++; if (ferr_seen + perr_seen + ovr_seen !== 0) begin tests_failed++; $display("FAIL basic_flags: got %0d pulses want 0", ferr_seen + perr_seen + ovr_seen); end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (5 * tick_div) @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL glitch_busy_during: got %b want 1", busy); end
    rx = 1'b1;
    repeat (2 * bit_clks()) @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy_after: got %b want 0", busy); end
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
    tests_run++; if (ferr_seen + perr_seen + ovr_seen !== 0) begin tests_failed++; $display("FAIL glitch_flags: got %0d pulses want 0", ferr_seen + perr_seen + ovr_seen); end
  endtask

  task automatic test_frame_err();
    logic [7:0] d = 8'h3C;
    send_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ parity_odd_sel);
`endif
    send_bit(1'b0);
    model_frame(d, 1'b0, 1'b1, 1'b0);
    repeat (3 * bit_clks()) @(negedge clk);
    tests_run++; if (ferr_seen !== exp_ferr) begin tests_failed++; $display("FAIL ferr_count: got %0d want %0d", ferr_seen, exp_ferr); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ferr_busy_break: got %b want 1", busy); end
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL ferr_valid: got %b want 0", rx_valid); end
    rx = 1'b1;
    repeat (8) @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ferr_busy_release: got %b want 0", busy); end
    run_frame(8'h11, 1'b1, 1'b1, 1'b0);
    tests_run++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin tests_failed++; $display("FAIL ferr_next_frame: got %0h/%b want 11/1", rx_data, rx_valid); end
    tests_run++; if (ferr_seen !== exp_ferr) begin tests_failed++; $display("FAIL ferr_single: got %0d want %0d", ferr_seen, exp_ferr); end
    do_ack();
  endtask

  task automatic test_overrun();
    run_frame(8'h12, 1'b1, 1'b1, 1'b0);
    run_frame(8'h34, 1'b1, 1'b1, 1'b0);
    tests_run++; if (ovr_seen !== exp_ovr) begin tests_failed++; $display("FAIL ovr_count: got %0d want %0d", ovr_seen, exp_ovr); end
    tests_run++; if (rx_data !== 8'h34) begin tests_failed++; $display("FAIL ovr_data: got %0h want 34", rx_data); end
    tests_run++; if (rx_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d = 8'hFF;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    repeat (bit_clks() / 2) @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    #2 reset = 1'b0;
    #1;
    tests_run++; if ({rx_data, rx_valid, frame_err, parity_err, overrun, busy} !== 13'b0) begin tests_failed++; $display("FAIL rstmid_outputs: got %0h/%b want all 0", rx_data, {rx_valid, frame_err, parity_err, overrun, busy}); end
    exp_valid = 1'b0;
    exp_data = 8'h00;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    run_frame(8'h81, 1'b1, 1'b1, 1'b0);
    tests_run++; if (rx_data !== 8'h81 || rx_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_next_frame: got %0h/%b want 81/1", rx_data, rx_valid); end
    do_ack();
  endtask

  // With baud_tick held high, the stop sample falls a fixed number of clocks
  // after the start edge (2 sync flops + IDLE->START + half bit + remaining bits)
  task automatic test_simul_ack();
    int ack_neg;
    int ovr_before;
    tick_div = 1;
    repeat (4) @(negedge clk);
    run_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    tests_run++; if (rx_data !== 8'h5A || rx_valid !== 1'b1) begin tests_failed++; $display("FAIL cont_tick_frame: got %0h/%b want 5a/1", rx_data, rx_valid); end
    ack_neg = 3 + OVERSAMPLE / 2 + OVERSAMPLE * (DATA_BITS + 1 + PBITS) - 1;
    ovr_before = ovr_seen;
    fork
      run_frame(8'hC3, 1'b1, 1'b1, 1'b1);
      begin
        repeat (ack_neg) @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
      end
    join
    tests_run++; if (rx_data !== 8'hC3 || rx_valid !== 1'b1) begin tests_failed++; $display("FAIL simul_load: got %0h/%b want c3/1", rx_data, rx_valid); end
    tests_run++; if (ovr_seen !== ovr_before) begin tests_failed++; $display("FAIL simul_no_overrun: got %0d want %0d", ovr_seen, ovr_before); end
    do_ack();
    tick_div = 4;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    parity_odd_sel = 1'b0;
    run_frame(8'h07, 1'b1, 1'b1, 1'b0);
    tests_run++; if (rx_data !== 8'h07 || rx_valid !== 1'b1) begin tests_failed++; $display("FAIL parity_good: got %0h/%b want 07/1", rx_data, rx_valid); end
    do_ack();
    run_frame(8'h07, 1'b1, 1'b0, 1'b0);
    tests_run++; if (perr_seen !== exp_perr) begin tests_failed++; $display("FAIL parity_err_count: got %0d want %0d", perr_seen, exp_perr); end
    tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL parity_bad_valid: got %b want 0", rx_valid); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] d;
    bit stop_ok, par_ok;
    for (int n = 0; n < 40; n++) begin
      tick_div = $urandom_range(1, 4);
      repeat (4) @(negedge clk);
      d = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
      par_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_odd_sel = 1'($urandom);
      par_ok = ($urandom_range(0, 5) != 0);
`endif
      run_frame(d, stop_ok, par_ok, 1'b0);
      tests_run++; if (rx_valid !== exp_valid || rx_data !== exp_data) begin tests_failed++; $display("FAIL rand_word[%0d]: got %0h/%b want %0h/%b", n, rx_data, rx_valid, exp_data, exp_valid); end
      tests_run++; if (ferr_seen !== exp_ferr || perr_seen !== exp_perr || ovr_seen !== exp_ovr) begin tests_failed++; $display("FAIL rand_flags[%0d]: got f%0d p%0d o%0d want f%0d p%0d o%0d", n, ferr_seen, perr_seen, ovr_seen, exp_ferr, exp_perr, exp_ovr); end
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL rand_ack[%0d]: got %b want 0", n, rx_valid); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_simul_ack();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
